inst_queue: RTL
===============

INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port flush  input  1  discard all entries (PC redirect).
REQ-005 SHALL have port in_valid  input  1  fetch stage presents an instruction.
REQ-006 SHALL have port in_ready  output  1  queue accepts an instruction this cycle.
REQ-007 SHALL have port in_pc  input  64  PC of the fetched instruction.
REQ-008 SHALL have port in_inst  input  32  fetched instruction word, already half-selected by pc[2].
REQ-009 SHALL have port out_valid  output  1  head entry available to decode.
REQ-010 SHALL have port out_ready  input  1  decode consumes the head entry.
REQ-011 SHALL have port out_pc  output  64  PC of the head entry.
REQ-012 SHALL have port out_inst  output  32  instruction of the head entry.
REQ-013 SHALL have port out_misalign  output  1  head entry PC has pc[1:0] != 0.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-015 Push SHALL occur on in_valid & in_ready; pop SHALL occur on out_valid & out_ready.
REQ-016 in_ready SHALL be !full & !flush; out_valid SHALL be !empty & !flush.
REQ-017 Storage SHALL be a circular buffer; read/write pointers SHALL be $clog2(DEPTH)+1 bits, with the MSB as the wrap bit; full = addresses equal & wrap bits differ; empty = pointers equal.
REQ-018 Latency SHALL be exactly 1 cycle from push to out_valid; there is no combinational in->out bypass.
REQ-019 A simultaneous push and pop when neither full nor empty SHALL leave count unchanged and keep FIFO order.
REQ-020 When full, a pop SHALL NOT enable a same-cycle push (in_ready stays 0 that cycle).
REQ-021 When empty, out_pc, out_inst and out_misalign SHALL be don't-care; the bench SHALL check them only while out_valid=1.
REQ-022 out_misalign SHALL be computed at push time from in_pc[1:0] and stored per entry.
REQ-023 flush SHALL take priority over push and pop: both pointers SHALL return to 0 at the next edge, and that cycle's push and pop SHALL be dropped.
REQ-024 count SHALL equal wptr - rptr (modulo 2*DEPTH), and SHALL be registered-derived with no glitch from the inputs.

Reset
REQ-025 When reset=0, pointers SHALL clear immediately, giving count=0, out_valid=0 and in_ready=1 once reset=1 (flush=0).
REQ-026 Entry storage SHALL NOT need reset.
REQ-027 Reset asserted mid-operation SHALL discard all entries regardless of handshakes in flight.

Configuration
REQ-028 With IQ_PERF_EN defined, the block SHALL add output stall_cnt (64 bit) counting cycles with in_valid & !in_ready & !flush, and output empty_cnt (64 bit) counting cycles with out_ready & !out_valid; both counters SHALL reset to 0 and saturate at all-ones.
REQ-029 Without IQ_PERF_EN, the block SHALL have neither these ports nor these counters.

Structure
REQ-030 A shared package SHALL hold the entry typedef {pc[63:0], inst[31:0], misalign} and the constants XLEN=64 and ILEN=32.
REQ-031 Pointer/full/empty logic SHALL be one sub-module, iq_ptr_ctrl; the storage array and the perf counters SHALL stay in inst_queue.

Verification
REQ-032 Reset then push PC 0x80000000 / inst 0x00000413 SHALL give out_valid=1 one cycle later, with matching out_pc/out_inst, out_misalign=0 and count=1.
REQ-033 Four pushes with out_ready=0 SHALL give count=4 and in_ready=0; a fifth in_valid SHALL be held; draining SHALL return PCs 0x80000000, 0x80000004, 0x80000008 and 0x8000000C in order.
REQ-034 Continuous push+pop at count=2 for 10 cycles SHALL hold count=2, and pointers SHALL wrap past DEPTH with order preserved.
REQ-035 flush with count=3 and in_valid=1 SHALL give count=0 and out_valid=0 next cycle, and the flushed-cycle PC SHALL never appear at the output.
REQ-036 Push of PC 0x80000002 SHALL give out_misalign=1 for that entry only.
REQ-037 With IQ_PERF_EN, 5 cycles of in_valid=1 while full SHALL give stall_cnt=5; reset asserted mid-stream SHALL give count=0 and stall_cnt=0 immediately.

Source files
------------

// File: rtl/inst_queue_pkg.sv
// Shared types and widths for the instruction queue between fetch and decode.
package inst_queue_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
        logic            misalign;
    } iq_entry_t;

endpackage

// File: rtl/iq_ptr_ctrl.sv
// Read/write pointer, full/empty and occupancy logic for the instruction queue.
module iq_ptr_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic                     out_ready,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic                     push,
    output logic [$clog2(DEPTH)-1:0] waddr,
    output logic [$clog2(DEPTH)-1:0] raddr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic        full;
    logic        empty;
    logic        pop;

    // MSB is the wrap bit: same address with differing wrap means full
    assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign empty = (wptr == rptr);

    assign in_ready  = !full && !flush;
    assign out_valid = !empty && !flush;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign waddr = wptr[AW-1:0];
    assign raddr = rptr[AW-1:0];
    assign count = wptr - rptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

endmodule

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue (circular buffer, 1-cycle latency).
// Define IQ_PERF_EN to add the stall_cnt/empty_cnt performance counters.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        in_pc,
    input  logic [ILEN-1:0]        in_inst,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_pc,
    output logic [ILEN-1:0]        out_inst,
    output logic                   out_misalign,
    output logic [$clog2(DEPTH):0] count
`ifdef IQ_PERF_EN
    ,
    output logic [63:0]            stall_cnt,
    output logic [63:0]            empty_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic          push;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    iq_entry_t     mem [DEPTH];
    iq_entry_t     head;

    iq_ptr_ctrl #(
        .DEPTH(DEPTH)
    ) u_ptr (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .out_ready(out_ready),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .push     (push),
        .waddr    (waddr),
        .raddr    (raddr),
        .count    (count)
    );

    always_ff @(posedge clk) begin
        if (push) begin
            mem[waddr] <= '{pc: in_pc, inst: in_inst,
                            misalign: (in_pc[1:0] != 2'b00)};
        end
    end

    assign head         = mem[raddr];
    assign out_pc       = head.pc;
    assign out_inst     = head.inst;
    assign out_misalign = head.misalign;

`ifdef IQ_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            empty_cnt <= '0;
        end else begin
            if (in_valid && !in_ready && !flush && stall_cnt != '1)
                stall_cnt <= stall_cnt + 64'd1;
            if (out_ready && !out_valid && empty_cnt != '1)
                empty_cnt <= empty_cnt + 64'd1;
        end
    end
`endif

endmodule
